// File: rtl/aurora_pkg.sv
// Shared Aurora RV64 pipeline types and constants.
// Used by fetch_unit, fetch_queue and the decode-side control_unit.
package aurora_pkg;

    localparam int XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {pc, instr} entries.
// Clear has priority over push and pop.
module fetch_queue
    import aurora_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 96,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Aurora RV64 instruction fetch stage: PC, imem requests, 2-entry queue.
// Optional FETCH_PERF_CNT_EN adds fetched/stall performance counters.
module fetch_unit
    import aurora_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetched_o,
    output logic [63:0]     perf_stall_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [CW-1:0]   outst_q;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   occ;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] target;
    logic [XLEN+31:0] head;
    logic            accept;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;

    assign target = redirect_pc_i & ~XLEN'(3);
    assign push   = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
    assign pop    = !empty && !stall_i && !redirect_i;

    // An entry leaving the queue this cycle frees its credit immediately.
    assign credit_used = {1'b0, outst_q} + {1'b0, occ} - (CW+1)'(pop);

    assign imem_req_valid_o = reset_i && !redirect_i
                            && (credit_used < (CW+1)'(DEPTH));
    assign accept      = imem_req_valid_o && imem_req_ready_i;
    assign imem_addr_o = pc_q;

    assign if_valid_o = !empty;
    assign if_instr_o = empty ? NOP_INSTR : head[31:0];
    assign if_pc_o    = empty ? '0 : head[XLEN+31:32];

    fetch_queue #(
        .DEPTH(DEPTH),
        .WIDTH(XLEN + 32)
    ) u_queue (
        .clk  (clk_i),
        .rst_n(reset_i),
        .push (push),
        .pop  (pop),
        .clear(redirect_i),
        .din  ({rsp_pc_q, imem_rsp_data_i}),
        .full (full),
        .empty(empty),
        .count(occ),
        .head (head)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else if (redirect_i) begin
            pc_q     <= target;
            rsp_pc_q <= target;
            outst_q  <= outst_q - CW'(imem_rsp_valid_i);
            drop_q   <= outst_q - CW'(imem_rsp_valid_i);
        end else begin
            if (accept) begin
                pc_q <= pc_q + STEP;
            end
            if (push) begin
                rsp_pc_q <= rsp_pc_q + STEP;
            end
            outst_q <= outst_q + CW'(accept) - CW'(imem_rsp_valid_i);
            if (imem_rsp_valid_i && drop_q != '0) begin
                drop_q <= drop_q - CW'(1);
            end
        end
    end

    always @(posedge clk_i) begin
        if (reset_i) begin
            assert (!(push && full))
            else $error("fetch queue overflow");
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (pop) begin
                perf_fetched_o <= perf_fetched_o + 64'd1;
            end
            if (if_valid_o && stall_i) begin
                perf_stall_o <= perf_stall_o + 64'd1;
            end
        end
    end
`endif

endmodule
